// File: rtl/cache_control_if.sv
// CPU-side request/response and physical-memory handshake for the L1 cache controller.
// The controller takes the slave view; the CPU/memory environment takes the master view.
interface cache_control_if #(
  parameter int s_offset = 5
);
  logic                   mem_read;
  logic                   mem_write;
  logic [2**s_offset-1:0] mem_byte_enable;
  logic                   mem_resp;
  logic                   pmem_read;
  logic                   pmem_write;
  logic                   pmem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control.sv
// Write-back direct-mapped L1 controller: hit/miss decision, writeback and fill
// sequencing against pmem, datapath write controls and saturating hit/miss counters.
module cache_control #(
  parameter int s_offset = 5,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_control_if.slave         bus,
  input  logic                   hit,
  input  logic                   dirty,
  output logic                   pmem_addr_sel,
  output logic [2**s_offset-1:0] data_write_en,
  output logic                   data_in_sel,
  output logic                   load_tag,
  output logic                   set_valid,
  output logic                   dirty_in,
  output logic                   load_dirty,
  input  logic                   cnt_clear,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       miss_count
);
  typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_e;

  state_e           state_q, state_d;
  logic             miss_flag_q, miss_flag_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;
  logic             req, mem_resp, pmem_read, pmem_write, hit_inc, miss_inc;

  assign req = bus.mem_read | bus.mem_write;

  always_comb begin
    state_d       = state_q;
    miss_flag_d   = miss_flag_q;
    miss_inc      = 1'b0;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    data_write_en = '0;
    data_in_sel   = 1'b0;
    load_tag      = 1'b0;
    set_valid     = 1'b0;
    dirty_in      = 1'b0;
    load_dirty    = 1'b0;
    case (state_q)
      CHECK: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          if (bus.mem_write) begin
            data_write_en = bus.mem_byte_enable;
            load_dirty    = 1'b1;
            dirty_in      = 1'b1;
          end
        end else if (req) begin
          miss_flag_d = 1'b1;
          miss_inc    = 1'b1;
          state_d     = dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (bus.pmem_resp) begin
          load_dirty = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          data_write_en = '1;
          data_in_sel   = 1'b1;
          load_tag      = 1'b1;
          set_valid     = 1'b1;
          load_dirty    = 1'b1;
          state_d       = CHECK;
        end
      end
      default: state_d = CHECK;
    endcase
    // Reset aborts in-flight transfers without touching the arrays.
    if (rst) begin
      miss_inc      = 1'b0;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      data_write_en = '0;
      data_in_sel   = 1'b0;
      load_tag      = 1'b0;
      set_valid     = 1'b0;
      dirty_in      = 1'b0;
      load_dirty    = 1'b0;
    end
    hit_inc = mem_resp & ~miss_flag_q;
    if (mem_resp) miss_flag_d = 1'b0;
  end

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (cnt_clear) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end else begin
      if (hit_inc && hit_count_q != '1)   hit_count_d  = hit_count_q + CNT_W'(1);
      if (miss_inc && miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CHECK;
      miss_flag_q  <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      miss_flag_q  <= miss_flag_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bus.mem_resp   = mem_resp;
  assign bus.pmem_read  = pmem_read;
  assign bus.pmem_write = pmem_write;
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;
endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: CHECK-state vector table, hand sequences for reset/clear/
// saturation, and random requests against a cache model with its own tag/valid/dirty arrays.
module tb_cache_control;
  localparam int SO = 5;
  localparam int LB = 2**SO;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hit = 1'b0, dirty_i = 1'b0, cnt_clear = 1'b0;
  logic          pmem_addr_sel, data_in_sel, load_tag, set_valid, dirty_in, load_dirty;
  logic [LB-1:0] data_write_en;
  logic [CW-1:0] hit_count, miss_count;

  cache_control_if #(.s_offset(SO)) bus();

  cache_control #(.s_offset(SO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hit(hit), .dirty(dirty_i),
    .pmem_addr_sel(pmem_addr_sel), .data_write_en(data_write_en),
    .data_in_sel(data_in_sel), .load_tag(load_tag), .set_valid(set_valid),
    .dirty_in(dirty_in), .load_dirty(load_dirty), .cnt_clear(cnt_clear),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cache model: arrays the datapath would hold, plus spec-level counters.
  bit [1:0] m_tag[8];
  bit       m_valid[8], m_dirty[8];
  int       m_hits, m_misses;
  bit       m_pend;
  int       cur_idx, lat_wb, lat_fill, pcnt;
  bit [1:0] cur_tag;

  logic          s_resp, s_prd, s_pwr, s_asel, s_presp, s_ltag, s_sval, s_ldirty, s_din, s_disel;
  logic [LB-1:0] s_dwe;

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // One clock; entered and left just after a negedge. Plays datapath and pmem.
  task automatic tick();
    hit           = m_valid[cur_idx] && (m_tag[cur_idx] == cur_tag);
    dirty_i       = m_dirty[cur_idx];
    bus.pmem_resp = 1'b0;
    #1;
    if (bus.pmem_write)     bus.pmem_resp = (pcnt == lat_wb);
    else if (bus.pmem_read) bus.pmem_resp = (pcnt == lat_fill);
    #1;
    s_resp = bus.mem_resp;  s_prd = bus.pmem_read; s_pwr = bus.pmem_write;
    s_asel = pmem_addr_sel; s_presp = bus.pmem_resp; s_ltag = load_tag;
    s_sval = set_valid;     s_ldirty = load_dirty;   s_din = dirty_in;
    s_disel = data_in_sel;  s_dwe = data_write_en;
    @(posedge clk);
    if (s_prd || s_pwr) pcnt = s_presp ? 0 : pcnt + 1;
    else                pcnt = 0;
    if (s_ltag)   m_tag[cur_idx]   = cur_tag;
    if (s_sval)   m_valid[cur_idx] = 1'b1;
    if (s_ldirty) m_dirty[cur_idx] = s_din;
    @(negedge clk);
  endtask

  // drop_after > 0 withdraws the request after that many cycles (miss only).
  task automatic do_req(bit wr, logic [LB-1:0] be, int idx, bit [1:0] tg, int lw, int lf, int drop_after);
    bit ehit, ewb, edirty, got;
    int ecyc, n, nwb, nrd, bad_sel, bad_fill;
    logic [LB-1:0] rdwe;
    cur_idx = idx; cur_tag = tg; lat_wb = lw; lat_fill = lf;
    ehit   = m_valid[idx] && (m_tag[idx] == tg);
    ewb    = !ehit && m_dirty[idx];
    ecyc   = ehit ? 1 : (ewb ? lw + 1 : 0) + lf + 3;
    edirty = (drop_after > 0) ? 1'b0 : (wr ? 1'b1 : (ehit ? m_dirty[idx] : 1'b0));
    if (!ehit) begin m_misses = sat(m_misses + 1); m_pend = 1'b1; end
    if (drop_after == 0) begin
      if (!m_pend) m_hits = sat(m_hits + 1);
      m_pend = 1'b0;
    end
    bus.mem_read = !wr; bus.mem_write = wr; bus.mem_byte_enable = be;
    n = 0; got = 0; nwb = 0; nrd = 0; bad_sel = 0; bad_fill = 0; rdwe = '0;
    while (!got && n < 200) begin
      if (drop_after > 0 && n == drop_after) begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      end
      tick();
      n++;
      if (s_pwr) begin nwb++; if (!s_asel) bad_sel++; end
      if (s_prd) begin nrd++; if (s_asel)  bad_sel++; end
      if (s_ltag && !(s_dwe == '1 && s_sval && s_ldirty && !s_din && s_disel)) bad_fill++;
      if (s_resp) begin got = 1'b1; rdwe = s_dwe; end
      if (drop_after > 0 && n == ecyc - 1) break;
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    if (drop_after == 0) begin
      chk("resp_cycles", n, ecyc);
      chk("resp_dwe", rdwe, wr ? be : '0);
    end else begin
      chk("drop_no_resp", got, 0);
      tick();
      chk("drop_back_idle", {s_prd, s_pwr, s_resp}, 3'b000);
    end
    chk("wb_cycles", nwb, ewb ? lw + 1 : 0);
    chk("fill_cycles", nrd, ehit ? 0 : lf + 1);
    chk("addr_sel", bad_sel, 0);
    chk("fill_ctrl", bad_fill, 0);
    chk("dirty_after", m_dirty[idx], edirty);
    chk("line_valid_tag", {m_valid[idx], m_tag[idx]}, {1'b1, tg});
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
  endtask

  typedef struct {
    logic          rd, wr;
    logic [LB-1:0] be;
    logic          h, d, presp;
    logic          resp;
    logic [LB-1:0] dwe;
    logic          ld, din;
  } vec_t;

  initial begin
    vec_t vt[7];
    logic any;
    int   nresp;

    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = '0; bus.pmem_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin m_tag[i] = 0; m_valid[i] = 0; m_dirty[i] = 0; end
    m_hits = 0; m_misses = 0; m_pend = 0; pcnt = 0; cur_idx = 0; cur_tag = 0;

    // reset, then five idle cycles with everything low
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      any |= bus.mem_resp | bus.pmem_read | bus.pmem_write | pmem_addr_sel | (|data_write_en) |
             data_in_sel | load_tag | set_valid | dirty_in | load_dirty | (|hit_count) | (|miss_count);
    end
    chk("idle_after_reset", any, 1'b0);
    @(negedge clk);

    // single-cycle CHECK-state vectors
    vt[0] = '{1'b0, 1'b0, '0,            1'b1, 1'b0, 1'b0, 1'b0, '0,            1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, '0,            1'b1, 1'b0, 1'b0, 1'b1, '0,            1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 32'h0000000F,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0000000F,  1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b1, 32'hFF000000,  1'b1, 1'b1, 1'b0, 1'b1, 32'hFF000000,  1'b1, 1'b1};
    vt[4] = '{1'b0, 1'b0, '0,            1'b0, 1'b1, 1'b1, 1'b0, '0,            1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 32'h00F00000,  1'b1, 1'b1, 1'b1, 1'b1, '0,            1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 32'hFFFFFFFF,  1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF,  1'b1, 1'b1};
    nresp = 0;
    for (int i = 0; i < 7; i++) begin
      bus.mem_read = vt[i].rd; bus.mem_write = vt[i].wr; bus.mem_byte_enable = vt[i].be;
      hit = vt[i].h; dirty_i = vt[i].d; bus.pmem_resp = vt[i].presp;
      #1;
      chk($sformatf("vec%0d", i),
          {bus.mem_resp, data_write_en, load_dirty, dirty_in, bus.pmem_read, bus.pmem_write,
           pmem_addr_sel, data_in_sel, load_tag, set_valid},
          {vt[i].resp, vt[i].dwe, vt[i].ld, vt[i].din, 6'b0});
      if (vt[i].resp) nresp++;
      @(negedge clk);
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.pmem_resp = 1'b0;
    chk("table_hit_count", hit_count, nresp);
    chk("table_miss_count", miss_count, 0);

    // clear wins over a simultaneous hit
    bus.mem_read = 1'b1; hit = 1'b1; cnt_clear = 1'b1;
    #1;
    chk("clear_hit_resp", bus.mem_resp, 1'b1);
    @(negedge clk);
    bus.mem_read = 1'b0; cnt_clear = 1'b0;
    chk("clear_hit_count", hit_count, 0);
    m_hits = 0;

    // read miss clean, 3-cycle fill; then dirty writeback path
    do_req(1'b0, '0, 1, 2'd1, 0, 3, 0);
    do_req(1'b1, 32'h0000000F, 1, 2'd1, 0, 0, 0);
    do_req(1'b1, 32'h000000F0, 1, 2'd2, 2, 1, 0);
    // dropped miss: transfer completes silently, next hit does not count as a hit
    do_req(1'b0, '0, 3, 2'd0, 0, 3, 2);
    do_req(1'b0, '0, 1, 2'd2, 0, 0, 0);

    // reset in the middle of a fill
    cur_idx = 5; cur_tag = 2'd3;
    bus.mem_read = 1'b1; hit = 1'b0; dirty_i = 1'b0; bus.pmem_resp = 1'b0;
    @(negedge clk); #1;
    chk("fill_started", bus.pmem_read, 1'b1);
    rst = 1'b1; bus.pmem_resp = 1'b1;
    #1;
    chk("rst_no_array_write", {load_tag, set_valid, load_dirty, data_write_en}, '0);
    @(negedge clk);
    rst = 1'b0; bus.mem_read = 1'b0; bus.pmem_resp = 1'b0;
    #1;
    chk("rst_pmem_read", bus.pmem_read, 1'b0);
    chk("rst_counters", {hit_count, miss_count}, '0);
    @(negedge clk);
    m_hits = 0; m_misses = 0; m_pend = 0; pcnt = 0;

    // saturation of the hit counter
    for (int i = 0; i < CMAX + 3; i++) do_req(1'b0, '0, 1, 2'd2, 0, 0, 0);
    chk("hit_saturated", hit_count, CMAX);

    // random traffic
    for (int i = 0; i < 30; i++)
      do_req(1'($urandom_range(0, 1)), LB'($urandom()), $urandom_range(0, 7),
             2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(0, 4), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
